// File: rtl/rand_pkg.sv
// -----------------------------------------------------------------------------
// rand_pkg
//   Shared definitions for the bounded random-number generator:
//     - state_t     : draw FSM states
//     - lfsr_taps() : maximal-length Fibonacci tap mask for widths 3..16
//     - calc_mask() : smallest all-ones mask covering 0..limit-1
// -----------------------------------------------------------------------------
package rand_pkg;

  localparam int LFSR_MIN_W = 3;
  localparam int LFSR_MAX_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_t;

  // Tap mask for a left-shifting Fibonacci LFSR: bit (t-1) is set for each
  // tap t of a primitive polynomial of degree n. The feedback bit is the XOR
  // of the masked state and is shifted in at bit 0.
  function automatic logic [15:0] lfsr_taps(input int n);
    logic [15:0] taps;
    case (n)
      3:       taps = 16'h0006; // 3,2
      4:       taps = 16'h000C; // 4,3
      5:       taps = 16'h0014; // 5,3
      6:       taps = 16'h0030; // 6,5
      7:       taps = 16'h0060; // 7,6
      8:       taps = 16'h00B8; // 8,6,5,4
      9:       taps = 16'h0110; // 9,5
      10:      taps = 16'h0240; // 10,7
      11:      taps = 16'h0500; // 11,9
      12:      taps = 16'h0829; // 12,6,4,1
      13:      taps = 16'h100D; // 13,4,3,1
      14:      taps = 16'h2015; // 14,5,3,1
      15:      taps = 16'h6000; // 15,14
      16:      taps = 16'hD008; // 16,15,13,4
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

  // Smallest 2^k-1 that is >= limit-1. A limit of 0 means "full range" and
  // yields all ones; a limit of 1 yields 0. The result is always < 2*limit,
  // which is what lets a single subtraction fold a rejected candidate back
  // into range.
  function automatic logic [15:0] calc_mask(input logic [15:0] limit);
    logic [15:0] target;
    logic [15:0] m;
    if (limit == 16'd0) begin
      return 16'hFFFF;
    end
    target = limit - 16'd1;
    m      = 16'd0;
    for (int i = 0; i < 16; i++) begin
      if (m < target) m = {m[14:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/rand_lfsr.sv
// -----------------------------------------------------------------------------
// rand_lfsr
//   Free-running maximal-length Fibonacci XOR LFSR. Steps once per clock,
//   loads a seed on request, and never holds the all-zero lock-up state.
//
//   Ports
//     clk   in  1  rising-edge clock
//     rst   in  1  asynchronous active-high reset, state returns to 1
//     load  in  1  synchronous seed strobe, takes priority over stepping
//     seed  in  N  seed value; 0 is replaced by 1
//     q     out N  current LFSR state
// -----------------------------------------------------------------------------
module rand_lfsr
  import rand_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] seed,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));

  logic fb;

  assign fb = ^(q & TAPS);

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= N'(1);
    end else if (load) begin
      // An all-zero seed would lock the XOR LFSR; substitute 1.
      q <= (seed == '0) ? N'(1) : seed;
    end else begin
      q <= {q[N-2:0], fb};
    end
  end

endmodule

// File: rtl/rand_range.sv
// -----------------------------------------------------------------------------
// rand_range
//   Draws uniformly distributed values in [0, limit) from a free-running LFSR
//   by masked rejection sampling. Each draw masks the low OUT_W LFSR bits to
//   the smallest power-of-two range covering the limit and retries while the
//   candidate falls outside [0, limit). After MAX_TRY attempts the last
//   candidate is folded into range by subtracting limit, so every draw
//   finishes in bounded time.
//
//   Parameters
//     N        LFSR width, 3..16
//     OUT_W    result width, 1..N
//     MAX_TRY  rejection attempts per draw, >= 1
//
//   Ports
//     clk        in  1      rising-edge clock
//     rst        in  1      asynchronous active-high reset
//     seed_load  in  1      load LFSR from seed; aborts a draw in progress
//     seed       in  N      seed value (0 loads 1)
//     req        in  1      draw request, accepted when ready
//     limit      in  OUT_W  exclusive upper bound, 0 = full range
//     ready      out 1      idle, a request will be accepted
//     valid      out 1      one-cycle result strobe
//     value      out OUT_W  result, held until the next valid
//     lfsr_q     out N      current LFSR state
// -----------------------------------------------------------------------------
module rand_range
  import rand_pkg::*;
#(
  parameter int N       = 8,
  parameter int OUT_W   = 8,
  parameter int MAX_TRY = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [N-1:0]     seed,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             ready,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic [N-1:0]     lfsr_q
);

  localparam int             TW       = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
  localparam logic [TW-1:0]  LAST_TRY = TW'(MAX_TRY - 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [OUT_W-1:0] limit_q, limit_d;
  logic [OUT_W-1:0] mask_q,  mask_d;
  logic [OUT_W-1:0] value_d;
  logic             valid_d;
  logic [OUT_W-1:0] cand;

  // ---------------------------------------------------------------------------
  // Random source
  // ---------------------------------------------------------------------------
  rand_lfsr #(
    .N (N)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (seed_load),
    .seed (seed),
    .q    (lfsr_q)
  );

  assign ready = (state_q == ST_IDLE);
  assign cand  = lfsr_q[OUT_W-1:0] & mask_q;

  // ---------------------------------------------------------------------------
  // Next-state and datapath decisions
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    limit_d = limit_q;
    mask_d  = mask_q;
    value_d = value;
    valid_d = 1'b0;

    if (seed_load) begin
      // Reseeding invalidates whatever the draw was consuming; drop it
      // without a result and without touching the held value.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            // Bound and mask are frozen here so a later change of limit
            // cannot disturb the draw in progress.
            limit_d = limit;
            mask_d  = OUT_W'(calc_mask(16'(limit)));
            tries_d = '0;
            state_d = ST_DRAW;
          end
        end

        ST_DRAW: begin
          if ((limit_q == '0) || (cand < limit_q)) begin
            value_d = cand;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else if (tries_q == LAST_TRY) begin
            // mask < 2*limit, so cand - limit is already inside [0, limit).
            value_d = cand - limit_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tries_d = tries_q + TW'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tries_q <= '0;
      limit_q <= '0;
      mask_q  <= '0;
      value   <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      limit_q <= limit_d;
      mask_q  <= mask_d;
      value   <= value_d;
      valid   <= valid_d;
    end
  end

endmodule

// File: tb/tb_rand_range.sv
// -----------------------------------------------------------------------------
// tb_rand_range
//   Directed bench for rand_range. Instance a uses the defaults
//   (N=8, OUT_W=8, MAX_TRY=16); instance b uses MAX_TRY=1 to exercise the
//   fold-back path. Inputs change and outputs are sampled on the falling
//   edge. Latency counts rising edges from the accepting edge t to the edge
//   at which valid is first seen high (minimum 2).
// -----------------------------------------------------------------------------
module tb_rand_range;

  logic       clk = 1'b0;
  logic       rst;

  logic       seed_load_a, req_a, ready_a, valid_a;
  logic [7:0] seed_a, limit_a, value_a, lfsr_a;

  logic       seed_load_b, req_b, ready_b, valid_b;
  logic [7:0] seed_b, limit_b, value_b, lfsr_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rand_range #(.N(8), .OUT_W(8), .MAX_TRY(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load_a),
    .seed      (seed_a),
    .req       (req_a),
    .limit     (limit_a),
    .ready     (ready_a),
    .valid     (valid_a),
    .value     (value_a),
    .lfsr_q    (lfsr_a)
  );

  rand_range #(.N(8), .OUT_W(8), .MAX_TRY(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load_b),
    .seed      (seed_b),
    .req       (req_b),
    .limit     (limit_b),
    .ready     (ready_b),
    .valid     (valid_b),
    .value     (value_b),
    .lfsr_q    (lfsr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance a (sel=0) or b (sel=1) from a falling
  // edge with the instance idle. Returns at the falling edge where valid is
  // seen, so a following call is a back-to-back request. limit is scrambled
  // after acceptance to confirm the captured bound is used.
  task automatic do_draw(input bit sel, input logic [7:0] lim,
                         output logic [7:0] val, output int lat);
    int k;
    if (sel) begin req_b = 1'b1; limit_b = lim; end
    else     begin req_a = 1'b1; limit_a = lim; end
    @(negedge clk);
    if (sel) begin req_b = 1'b0; limit_b = ~lim; end
    else     begin req_a = 1'b0; limit_a = ~lim; end
    check("accept_ready_low", sel ? ready_b : ready_a, 0);
    check("valid_one_cycle",  sel ? valid_b : valid_a, 0);
    k   = 1;
    lat = 0;
    while (lat == 0 && k <= 20) begin
      @(negedge clk);
      k++;
      if (sel ? valid_b : valid_a) lat = k;
    end
    if (lat == 0) check("draw_timeout", sel ? valid_b : valid_a, 1);
    val = sel ? value_b : value_a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, v0;
    int         lat;
    bit         seen [256];
    int         distinct;
    logic [5:0] hit;
    bit         ok;

    rst = 1'b1;
    seed_load_a = 1'b0; seed_a = '0; req_a = 1'b0; limit_a = '0;
    seed_load_b = 1'b0; seed_b = '0; req_b = 1'b0; limit_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_lfsr_a", lfsr_a, 8'h01);
    check("rst_ready_a", ready_a, 1);
    check("rst_valid_a", valid_a, 0);
    check("rst_value_a", value_a, 0);
    check("rst_lfsr_b", lfsr_b, 8'h01);
    rst = 1'b0;

    // Free-running period: 255 distinct nonzero states, back to 1 at 255
    foreach (seen[i]) seen[i] = 1'b0;
    seen[1]  = 1'b1;
    distinct = 1;
    ok       = 1'b1;
    for (int i = 1; i < 255; i++) begin
      @(negedge clk);
      if (lfsr_a == 8'h00 || seen[lfsr_a]) ok = 1'b0;
      else begin seen[lfsr_a] = 1'b1; distinct++; end
    end
    check("period_distinct", distinct, 255);
    check("period_no_repeat", ok, 1);
    @(negedge clk);
    check("period_return_1", lfsr_a, 8'h01);

    // Seed handling
    seed_load_a = 1'b1; seed_a = 8'h00;
    @(negedge clk);
    check("seed_zero", lfsr_a, 8'h01);
    seed_a = 8'hA5;
    @(negedge clk);
    check("seed_a5", lfsr_a, 8'hA5);
    seed_load_a = 1'b0;

    // Full range: value is the LFSR state seen between t and t+1 (A5 -> 4A)
    do_draw(0, 8'd0, v, lat);
    check("full_value", v, 8'h4A);
    check("full_latency", lat, 2);
    check("full_lfsr", lfsr_a, 8'h95);

    // Rejection then accept: 0x41 -> 0x82 (130, rejected) -> 0x05
    seed_load_a = 1'b1; seed_a = 8'h41;
    @(negedge clk);
    seed_load_a = 1'b0;
    do_draw(0, 8'd129, v, lat);
    check("reject_value", v, 8'd5);
    check("reject_latency", lat, 3);

    // Fold-back on the single-try instance: 130 - 129 = 1
    seed_load_b = 1'b1; seed_b = 8'h41;
    @(negedge clk);
    seed_load_b = 1'b0;
    do_draw(1, 8'd129, v, lat);
    check("fold_value", v, 8'd1);
    check("fold_latency", lat, 2);

    // limit = 1: mask 0, result always 0
    do_draw(0, 8'd1, v, lat);
    check("limit1_value", v, 8'd0);
    check("limit1_latency", lat, 2);

    // limit = 6, 1000 back-to-back requests
    hit = '0;
    for (int i = 0; i < 1000; i++) begin
      do_draw(0, 8'd6, v, lat);
      check("lim6_range", (v < 8'd6), 1);
      check("lim6_latency", (lat >= 2 && lat <= 17), 1);
      if (v < 8'd6) hit[v[2:0]] = 1'b1;
    end
    check("lim6_coverage", hit, 6'h3F);

    // MAX_TRY=1, limit 129: fixed latency, always in range
    for (int i = 0; i < 500; i++) begin
      do_draw(1, 8'd129, v, lat);
      check("mt1_latency", lat, 2);
      check("mt1_range", (v < 8'd129), 1);
    end

    // seed_load during DRAW aborts without valid
    v0 = value_a;
    req_a = 1'b1; limit_a = 8'd6;
    @(negedge clk);
    req_a = 1'b0;
    check("abort_seed_in_draw", ready_a, 0);
    seed_load_a = 1'b1; seed_a = 8'h33;
    @(negedge clk);
    seed_load_a = 1'b0;
    check("abort_seed_valid", valid_a, 0);
    check("abort_seed_ready", ready_a, 1);
    check("abort_seed_value", value_a, v0);
    check("abort_seed_lfsr", lfsr_a, 8'h33);
    // 0x33 -> 0x66 (cand 6, rejected) -> 0xCD (cand 5)
    do_draw(0, 8'd6, v, lat);
    check("after_seed_value", v, 8'd5);
    check("after_seed_latency", lat, 3);

    // Reset during DRAW discards the draw
    req_a = 1'b1; limit_a = 8'd6;
    @(negedge clk);
    req_a = 1'b0;
    check("abort_rst_in_draw", ready_a, 0);
    rst = 1'b1;
    #1;
    check("abort_rst_ready", ready_a, 1);
    check("abort_rst_valid", valid_a, 0);
    check("abort_rst_value", value_a, 0);
    check("abort_rst_lfsr", lfsr_a, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    check("abort_rst_no_valid", valid_a, 0);
    // 0x01 -> 0x02 (cand 2)
    do_draw(0, 8'd6, v, lat);
    check("after_rst_value", v, 8'd2);
    check("after_rst_latency", lat, 2);
    @(negedge clk);
    check("after_rst_valid_drop", valid_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rand_range.md
RAND_RANGE -- requirements
Module: rand_range

Interface
REQ-001 SHALL have parameter N, default 8: LFSR width, legal 3..16.
REQ-002 SHALL have parameter OUT_W, default 8: result width, legal 1..N.
REQ-003 SHALL have parameter MAX_TRY, default 16: rejection attempts per draw, legal >=1.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port seed_load  input  1  synchronous seed strobe.
REQ-007 SHALL have port seed  input  N  seed value.
REQ-008 SHALL have port req  input  1  draw request.
REQ-009 SHALL have port limit  input  OUT_W  exclusive upper bound; 0 = full range.
REQ-010 SHALL have port ready  output  1  high when a request can be accepted.
REQ-011 SHALL have port valid  output  1  one-cycle result strobe.
REQ-012 SHALL have port value  output  OUT_W  drawn result, held until next valid.
REQ-013 SHALL have port lfsr_q  output  N  current LFSR state, free-running.

Function
REQ-014 The LFSR SHALL be a maximal-length Fibonacci XOR LFSR with taps from the package table for N, advancing every cycle.
REQ-015 The LFSR SHALL never hold all-zeros; seed_load with seed==0 SHALL load 1.
REQ-016 seed_load SHALL load the LFSR on that edge instead of stepping, with priority over stepping and draw logic.
REQ-017 The FSM SHALL have states IDLE and DRAW; ready = (state==IDLE).
REQ-018 In IDLE with req=1, the FSM SHALL capture limit and the mask, clear the try counter, and enter DRAW; req is ignored while in DRAW.
REQ-019 mask SHALL be the smallest 2^k-1 >= limit-1, with all-ones for limit==0 and 0 for limit==1.
REQ-020 In DRAW, each cycle: candidate = lfsr_q[OUT_W-1:0] & mask.
REQ-021 In DRAW, if limit==0 or candidate<limit, the block SHALL register value<=candidate, pulse valid, and return to IDLE.
REQ-022 Otherwise, if tries==MAX_TRY-1, the block SHALL register value<=candidate-limit (always <limit, because mask<2*limit), pulse valid, and return to IDLE.
REQ-023 Otherwise the block SHALL increment tries and stay in DRAW.
REQ-024 Latency: valid SHALL be high in cycle t+2 minimum and t+MAX_TRY+1 maximum, where req is sampled at edge t.
REQ-025 valid SHALL be high exactly one cycle per accepted request; back-to-back requests SHALL be accepted the cycle valid is high.
REQ-026 seed_load in DRAW SHALL abort the draw: state returns to IDLE, no valid, value unchanged.
REQ-027 A change of limit during DRAW SHALL have no effect on the draw in progress.

Reset
REQ-028 While rst is high, lfsr_q SHALL be 1, state IDLE, tries 0, valid 0, value 0, ready 1, with asynchronous assertion and release on the clk edge.
REQ-029 Reset mid-draw SHALL discard the draw without producing valid.

Structure
REQ-030 Package rand_pkg SHALL hold the tap table/function for N=3..16, the FSM state enum, and a mask-computation function.
REQ-031 Sub-module rand_lfsr (params N; ports clk, rst, load, seed, q) SHALL implement REQ-014 to REQ-016; rand_range instantiates it.

Verification
REQ-032 N=8, no stimulus after reset -> lfsr_q visits 255 distinct nonzero states and equals 1 again at cycle 255.
REQ-033 seed_load=1 with seed=0 -> lfsr_q==1 next cycle; seed=8'hA5 -> lfsr_q==8'hA5 next cycle.
REQ-034 limit=6, 1000 requests -> every value in 0..5, each of 0..5 observed, valid always one cycle wide, latency 2..17.
REQ-035 limit=0 -> valid at t+2 with value == lfsr_q[7:0] sampled at edge t+1.
REQ-036 MAX_TRY=1, limit=129, 500 requests -> every latency exactly 2, every value <129.
REQ-037 seed_load or rst asserted in DRAW -> no valid, ready=1 next cycle, and the next request completes normally.
